// File: rtl/memory_access_pipe.sv
// Y86-64 data-memory stage: valid/ready request/response around an internal
// little-endian byte memory with a fixed, parameterised access latency.
module memory_access_pipe #(
  parameter int unsigned MEM_BYTES   = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned CHECK_ALIGN = 0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [3:0]  icode_i,
  input  logic [63:0] valE_i,
  input  logic [63:0] valA_i,
  input  logic [63:0] valP_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [63:0] valM_o,
  output logic        dmem_error_o,
  output logic        err_sticky_o
);

  localparam int unsigned AW       = $clog2(MEM_BYTES);
  localparam int unsigned CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES - 8);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          wr_q;
  logic [63:0]   addr_q;
  logic [63:0]   wdata_q;
  logic [63:0]   valM_q;
  logic          err_q;
  logic          sticky_q;

  logic [7:0]    mem [MEM_BYTES];

  logic          req_is_mem_d;
  logic          req_is_wr_d;
  logic [63:0]   req_addr_d;
  logic [63:0]   req_wdata_d;
  logic          acc_err_d;
  logic [63:0]   rdata_d;
  logic          do_write_d;

  always_comb begin
    req_is_mem_d = 1'b0;
    req_is_wr_d  = 1'b0;
    unique case (icode_i)
      4'h4, 4'h8, 4'hA: begin
        req_is_mem_d = 1'b1;
        req_is_wr_d  = 1'b1;
      end
      4'h5, 4'h9, 4'hB: req_is_mem_d = 1'b1;
      default: ;
    endcase
    req_addr_d  = (icode_i == 4'h9 || icode_i == 4'hB) ? valA_i : valE_i;
    req_wdata_d = (icode_i == 4'h8) ? valP_i : valA_i;
  end

  // Full 64-bit compare so huge addresses cannot wrap into range.
  always_comb begin
    acc_err_d = (addr_q > MAX_ADDR) || ((CHECK_ALIGN != 0) && (addr_q[2:0] != 3'b000));
    rdata_d   = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      rdata_d[8*i +: 8] = mem[addr_q[AW-1:0] + AW'(i)];
    end
    do_write_d = (state_q == WAIT) && (cnt_q == '0) && wr_q && !acc_err_d;
  end

  // No reset on the array; gating with rst_n_i drops a write hit by reset.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && do_write_d) begin
      for (int unsigned i = 0; i < 8; i++) begin
        mem[addr_q[AW-1:0] + AW'(i)] <= wdata_q[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      valM_q   <= '0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            wr_q    <= req_is_wr_d;
            addr_q  <= req_addr_d;
            wdata_q <= req_wdata_d;
            if (req_is_mem_d) begin
              state_q <= WAIT;
              cnt_q   <= CW'(LATENCY - 1);
            end else begin
              state_q <= RESP;
              valM_q  <= '0;
              err_q   <= 1'b0;
            end
          end
        end
        WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            state_q <= RESP;
            err_q   <= acc_err_d;
            valM_q  <= (acc_err_d || wr_q) ? '0 : rdata_d;
            if (acc_err_d) sticky_q <= 1'b1;
          end
        end
        RESP: begin
          if (resp_ready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o  = rst_n_i && (state_q == IDLE);
  assign resp_valid_o = (state_q == RESP);
  assign valM_o       = valM_q;
  assign dmem_error_o = err_q;
  assign err_sticky_o = sticky_q;

endmodule

// File: tb/tb_memory_access_pipe.sv
// Scoreboard bench for memory_access_pipe: two instances, one LATENCY=2 without
// alignment checking and one LATENCY=4 with alignment checking.
module tb_memory_access_pipe;

  localparam int unsigned MEMB = 1024;

  typedef struct {
    int          d;
    logic [63:0] valM;
    logic        err;
    logic        sticky;
    int unsigned lat;
  } exp_t;

  logic        clk;
  logic [1:0]  rst_n, req_valid, req_ready, resp_valid, resp_ready, dmem_err, sticky;
  logic [3:0]  icode [2];
  logic [63:0] valE [2];
  logic [63:0] valA [2];
  logic [63:0] valP [2];
  logic [63:0] valM [2];

  int unsigned lat_p [2]   = '{2, 4};
  bit          align_p [2] = '{1'b0, 1'b1};
  logic [7:0]  mdl [2][MEMB];
  logic        sticky_m [2];
  exp_t        sbq [$];

  int checks   = 0;
  int failures = 0;

  memory_access_pipe #(.MEM_BYTES(MEMB), .LATENCY(2), .CHECK_ALIGN(0)) u_dut0 (
    .clk_i(clk), .rst_n_i(rst_n[0]), .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
    .icode_i(icode[0]), .valE_i(valE[0]), .valA_i(valA[0]), .valP_i(valP[0]),
    .resp_valid_o(resp_valid[0]), .resp_ready_i(resp_ready[0]), .valM_o(valM[0]),
    .dmem_error_o(dmem_err[0]), .err_sticky_o(sticky[0])
  );

  memory_access_pipe #(.MEM_BYTES(MEMB), .LATENCY(4), .CHECK_ALIGN(1)) u_dut1 (
    .clk_i(clk), .rst_n_i(rst_n[1]), .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
    .icode_i(icode[1]), .valE_i(valE[1]), .valA_i(valA[1]), .valP_i(valP[1]),
    .resp_valid_o(resp_valid[1]), .resp_ready_i(resp_ready[1]), .valM_o(valM[1]),
    .dmem_error_o(dmem_err[1]), .err_sticky_o(sticky[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference behaviour of one request: computes the response and updates the model.
  task automatic send(input int d, input logic [3:0] ic, input logic [63:0] e,
                      input logic [63:0] a, input logic [63:0] p);
    exp_t        x;
    logic        is_mem, is_wr;
    logic [63:0] addr, wd;
    int          n;
    is_mem = ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    is_wr  = ic inside {4'h4, 4'h8, 4'hA};
    addr   = (ic == 4'h9 || ic == 4'hB) ? a : e;
    wd     = (ic == 4'h8) ? p : a;
    x.d    = d;
    x.valM = '0;
    x.err  = is_mem && ((addr > 64'(MEMB - 8)) || (align_p[d] && addr[2:0] != 3'b000));
    x.lat  = is_mem ? lat_p[d] : 0;
    if (x.err) sticky_m[d] = 1'b1;
    if (is_mem && !x.err) begin
      for (int k = 0; k < 8; k++) begin
        if (is_wr) mdl[d][int'(addr[9:0]) + k] = wd[8*k +: 8];
        else       x.valM[8*k +: 8] = mdl[d][int'(addr[9:0]) + k];
      end
    end
    x.sticky = sticky_m[d];
    sbq.push_back(x);

    @(negedge clk);
    icode[d] = ic; valE[d] = e; valA[d] = a; valP[d] = p;
    req_valid[d] = 1'b1;
    n = 0;
    while (!req_ready[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq($sformatf("d%0d_req_ready", d), {63'd0, req_ready[d]}, 64'd1);
    @(posedge clk);
    #1 req_valid[d] = 1'b0;
  endtask

  task automatic collect(input int d, output exp_t x);
    int n;
    n = 0;
    @(negedge clk);
    while (!resp_valid[d] && n < 60) begin
      @(negedge clk);
      n++;
    end
    check_eq($sformatf("d%0d_sb_nonempty", d), 64'(sbq.size() > 0), 64'd1);
    if (sbq.size() > 0) x = sbq.pop_front();
    else begin
      x.d = d; x.valM = '0; x.err = 1'b0; x.sticky = 1'b0; x.lat = 0;
    end
    check_eq($sformatf("d%0d_sb_dut", d), 64'(x.d), 64'(d));
    check_eq($sformatf("d%0d_resp_lat", d), 64'(n), 64'(x.lat));
    check_eq($sformatf("d%0d_valM", d), valM[d], x.valM);
    check_eq($sformatf("d%0d_err", d), {63'd0, dmem_err[d]}, {63'd0, x.err});
    check_eq($sformatf("d%0d_sticky", d), {63'd0, sticky[d]}, {63'd0, x.sticky});
  endtask

  task automatic release_resp(input int d);
    resp_ready[d] = 1'b1;
    @(posedge clk);
    #1 resp_ready[d] = 1'b0;
  endtask

  task automatic do_op(input int d, input logic [3:0] ic, input logic [63:0] e,
                       input logic [63:0] a, input logic [63:0] p);
    exp_t x;
    send(d, ic, e, a, p);
    collect(d, x);
    release_resp(d);
  endtask

  task automatic check_reset_vals(input int d, input string tag);
    check_eq({tag, "_resp_valid"}, {63'd0, resp_valid[d]}, 64'd0);
    check_eq({tag, "_valM"}, valM[d], 64'd0);
    check_eq({tag, "_err"}, {63'd0, dmem_err[d]}, 64'd0);
    check_eq({tag, "_sticky"}, {63'd0, sticky[d]}, 64'd0);
    check_eq({tag, "_req_ready"}, {63'd0, req_ready[d]}, 64'd0);
  endtask

  initial begin
    exp_t x;
    rst_n = 2'b00; req_valid = '0; resp_ready = '0;
    for (int d = 0; d < 2; d++) begin
      icode[d] = '0; valE[d] = '0; valA[d] = '0; valP[d] = '0; sticky_m[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) check_reset_vals(d, $sformatf("d%0d_rst", d));
    rst_n = 2'b11;
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      check_eq($sformatf("d%0d_ready_after_rst", d), {63'd0, req_ready[d]}, 64'd1);

    // Write/read round trip at both latencies.
    for (int d = 0; d < 2; d++) begin
      do_op(d, 4'h4, 64'h10, 64'h1122334455667788, 64'h0);
      do_op(d, 4'h5, 64'h10, 64'h0, 64'h0);
    end

    // Unaligned read: legal without alignment checking, error with it.
    for (int d = 0; d < 2; d++) begin
      do_op(d, 4'h4, 64'h18, 64'h0, 64'h0);
      do_op(d, 4'h5, 64'h11, 64'h0, 64'h0);
    end

    // Top-of-memory boundary and no wrap-around.
    do_op(0, 4'h4, 64'(MEMB - 8), 64'hCAFEF00DDEADBEEF, 64'h0);
    do_op(0, 4'h4, 64'(MEMB - 7), 64'h0123456789ABCDEF, 64'h0);
    do_op(0, 4'h5, 64'(MEMB - 8), 64'h0, 64'h0);
    do_op(0, 4'h5, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 64'h0);

    // call/ret, non-memory op, push/pop.
    do_op(0, 4'h8, 64'h20, 64'h0, 64'h55);
    do_op(0, 4'h9, 64'h0, 64'h20, 64'h0);
    do_op(0, 4'h6, 64'h10, 64'h99, 64'h77);
    do_op(0, 4'hA, 64'h40, 64'hA5A5_0000_FFFF_1234, 64'h0);
    do_op(0, 4'hB, 64'h0, 64'h40, 64'h0);

    // Stalled response with request pulses that must not be accepted.
    send(0, 4'h5, 64'h10, 64'h0, 64'h0);
    collect(0, x);
    for (int k = 0; k < 3; k++) begin
      icode[0] = 4'h4; valE[0] = 64'h10; valA[0] = 64'hDEAD_DEAD_DEAD_DEAD;
      req_valid[0] = (k != 1);
      @(negedge clk);
      check_eq($sformatf("stall%0d_resp_valid", k), {63'd0, resp_valid[0]}, 64'd1);
      check_eq($sformatf("stall%0d_valM", k), valM[0], x.valM);
      check_eq($sformatf("stall%0d_err", k), {63'd0, dmem_err[0]}, {63'd0, x.err});
      check_eq($sformatf("stall%0d_req_ready", k), {63'd0, req_ready[0]}, 64'd0);
    end
    req_valid[0] = 1'b0;
    release_resp(0);
    @(negedge clk);
    check_eq("stall_done_resp_valid", {63'd0, resp_valid[0]}, 64'd0);
    check_eq("stall_done_req_ready", {63'd0, req_ready[0]}, 64'd1);
    do_op(0, 4'h5, 64'h10, 64'h0, 64'h0);

    // Reset in the middle of a LATENCY=4 write drops it.
    do_op(1, 4'h4, 64'h30, 64'h0BAD_F00D_1234_5678, 64'h0);
    @(negedge clk);
    icode[1] = 4'h4; valE[1] = 64'h30; valA[1] = 64'hFFFF_EEEE_DDDD_CCCC;
    req_valid[1] = 1'b1;
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(posedge clk);
    #1 rst_n[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_vals(1, "mid_rst");
    @(posedge clk);
    #1 rst_n[1] = 1'b1;
    sticky_m[1] = 1'b0;
    @(negedge clk);
    check_eq("post_rst_req_ready", {63'd0, req_ready[1]}, 64'd1);
    check_eq("post_rst_resp_valid", {63'd0, resp_valid[1]}, 64'd0);
    do_op(1, 4'h5, 64'h30, 64'h0, 64'h0);

    check_eq("sb_drained", 64'(sbq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
